pkt_merger: RTL and testbench

PKT_MERGER -- requirements
Module: pkt_merger

---
 rtl/pkt_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/pkt_merger.sv | 91 +++++++++
 tb/tb_pkt_merger.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared packet definitions for the merger and router blocks.
package pkt_pkg;

  localparam int DEF_PACKET_BITS  = 72;
  localparam int DEF_NUM_CHANNELS = 8;
  localparam int DEF_CHAN_BITS    = $clog2(DEF_NUM_CHANNELS);

  typedef logic [DEF_PACKET_BITS-1:0] pkt_t;
  typedef logic [DEF_CHAN_BITS-1:0]   chan_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter
  import pkt_pkg::*;
#(
  parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
  localparam int CHAN_BITS    = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req_i,
  input  logic [CHAN_BITS-1:0]    ptr_i,
  output logic [CHAN_BITS-1:0]    grant_o,
  output logic                    grant_vld_o
);

  // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    grant_o     = '0;
    grant_vld_o = 1'b0;
    // Scan from the farthest offset back to ptr so the nearest requester wins;
    // the index wraps for free because NUM_CHANNELS is a power of two.
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      if (req_i[ptr_i + CHAN_BITS'(k)]) begin
        grant_o     = ptr_i + CHAN_BITS'(k);
        grant_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_merger.sv
// Merges NUM_CHANNELS valid/ready packet streams into one through a
// round-robin arbiter and a one-entry output register.
module pkt_merger
  import pkt_pkg::*;
#(
  parameter  int PACKET_BITS  = DEF_PACKET_BITS,
  parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
  localparam int CHAN_BITS    = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_BITS-1:0]  pkt_in_data_in [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] pkt_in_vld_in,
  output logic [NUM_CHANNELS-1:0] pkt_in_rdy_out,
  output logic [PACKET_BITS-1:0]  pkt_out_data_out,
  output logic [CHAN_BITS-1:0]    pkt_out_chan_out,
  output logic                    pkt_out_vld_out,
  input  logic                    pkt_out_rdy_in,
  output logic [31:0]             pkt_cnt_out
);

  logic [PACKET_BITS-1:0] data_q, data_d;
  logic [CHAN_BITS-1:0]   chan_q, chan_d;
  logic [CHAN_BITS-1:0]   ptr_q, ptr_d;
  logic                   vld_q, vld_d;
  logic [31:0]            cnt_q, cnt_d;

  logic [CHAN_BITS-1:0]   grant;
  logic                   grant_vld;
  logic                   load_en;
  logic                   in_xfer;
  logic                   out_xfer;

  rr_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_rr_arbiter (
    .req_i      (pkt_in_vld_in),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .grant_vld_o(grant_vld)
  );

  // The register may take a new packet when empty or when it drains this cycle.
  assign load_en  = !vld_q || pkt_out_rdy_in;
  assign in_xfer  = load_en && grant_vld && !reset;
  assign out_xfer = vld_q && pkt_out_rdy_in;

  always_comb begin
    pkt_in_rdy_out = '0;
    if (in_xfer) pkt_in_rdy_out[grant] = 1'b1;
  end

  always_comb begin
    data_d = data_q;
    chan_d = chan_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    cnt_d  = out_xfer ? cnt_q + 32'd1 : cnt_q;
    if (in_xfer) begin
      data_d = pkt_in_data_in[grant];
      chan_d = grant;
      vld_d  = 1'b1;
      ptr_d  = grant + CHAN_BITS'(1);
    end else if (out_xfer) begin
      vld_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      chan_q <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      chan_q <= chan_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pkt_out_data_out = data_q;
  assign pkt_out_chan_out = chan_q;
  assign pkt_out_vld_out  = vld_q;
  assign pkt_cnt_out      = cnt_q;

endmodule

// File: tb/tb_pkt_merger.sv
// Self-checking bench for pkt_merger: directed scenarios plus a randomized
// run scored against a queue-based reference model.
module tb_pkt_merger;
  import pkt_pkg::*;

  localparam int N = DEF_NUM_CHANNELS;

  logic          clk = 1'b0;
  logic          reset;
  pkt_t          data_in [N];
  logic [N-1:0]  vld_in;
  logic [N-1:0]  rdy_out;
  pkt_t          data_out;
  chan_t         chan_out;
  logic          vld_out;
  logic          rdy_in;
  logic [31:0]   cnt_out;

  int checks = 0;
  int errors = 0;

  // Reference-model state for the randomized run.
  pkt_t sb_q [N][$];
  pkt_t head [N];
  int   seq_n [N];
  int   wait_cnt [N];

  always #5 clk = ~clk;

  pkt_merger dut (
    .clk             (clk),
    .reset           (reset),
    .pkt_in_data_in  (data_in),
    .pkt_in_vld_in   (vld_in),
    .pkt_in_rdy_out  (rdy_out),
    .pkt_out_data_out(data_out),
    .pkt_out_chan_out(chan_out),
    .pkt_out_vld_out (vld_out),
    .pkt_out_rdy_in  (rdy_in),
    .pkt_cnt_out     (cnt_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pkt_t rand_pkt();
    return pkt_t'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic pkt_t mk_pkt(int ch, int s);
    return {8'(ch), 32'(s), 32'($urandom())};
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    vld_in = '0;
    rdy_in = 1'b1;
    for (int i = 0; i < N; i++) data_in[i] = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    vld_in = '1;
    rdy_in = 1'b1;
    for (int i = 0; i < N; i++) data_in[i] = rand_pkt();
    #1;
    checks++;
    if (rdy_out !== '0) begin errors++; $display("FAIL reset_rdy_comb: got %b expected 0", rdy_out); end
    tick();
    checks++;
    if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", vld_out); end
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
    checks++;
    if (chan_out !== '0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", chan_out); end
    checks++;
    if (cnt_out !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_out); end
    checks++;
    if (rdy_out !== '0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", rdy_out); end
    reset  = 1'b0;
    vld_in = '0;
  endtask

  task automatic test_all_channels();
    logic [N-1:0] exp_rdy;
    int           prev;
    do_reset();
    for (int i = 0; i < N; i++) data_in[i] = rand_pkt();
    vld_in = '1;
    rdy_in = 1'b1;
    for (int k = 0; k <= N; k++) begin
      #1;
      exp_rdy = '0;
      exp_rdy[k % N] = 1'b1;
      checks++;
      if (rdy_out !== exp_rdy) begin
        errors++; $display("FAIL all_grant[%0d]: got %b expected %b", k, rdy_out, exp_rdy);
      end
      if (k > 0) begin
        prev = (k - 1) % N;
        checks++;
        if (vld_out !== 1'b1 || chan_out !== chan_t'(prev) || data_out !== data_in[prev]) begin
          errors++;
          $display("FAIL all_out[%0d]: got vld=%b chan=%0d data=%h expected vld=1 chan=%0d data=%h",
                   k, vld_out, chan_out, data_out, prev, data_in[prev]);
        end
      end
      tick();
    end
    checks++;
    if (cnt_out !== 32'(N)) begin errors++; $display("FAIL all_cnt: got %0d expected %0d", cnt_out, N); end
    checks++;
    if (chan_out !== chan_t'(0)) begin errors++; $display("FAIL all_wrap_chan: got %0d expected 0", chan_out); end
    vld_in = '0;
  endtask

  task automatic test_single_channel();
    pkt_t d0;
    d0 = 72'h0A_DEAD_BEEF_0000_0001;
    do_reset();
    rdy_in = 1'b1;
    vld_in = '0;
    vld_in[5] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_in[5] = d0 + pkt_t'(k);
      #1;
      checks++;
      if (rdy_out !== 8'b0010_0000) begin
        errors++; $display("FAIL single_grant[%0d]: got %b expected 00100000", k, rdy_out);
      end
      if (k > 0) begin
        checks++;
        if (vld_out !== 1'b1 || chan_out !== chan_t'(5) || data_out !== d0 + pkt_t'(k - 1)) begin
          errors++;
          $display("FAIL single_out[%0d]: got vld=%b chan=%0d data=%h expected vld=1 chan=5 data=%h",
                   k, vld_out, chan_out, data_out, d0 + pkt_t'(k - 1));
        end
      end
      tick();
    end
    // Pointer now sits at 6: with 4, 5 and 6 all valid, 6 must win.
    data_in[4] = rand_pkt();
    data_in[6] = rand_pkt();
    vld_in = 8'b0111_0000;
    #1;
    checks++;
    if (rdy_out !== 8'b0100_0000) begin errors++; $display("FAIL single_ptr6: got %b expected 01000000", rdy_out); end
    tick();
    checks++;
    if (chan_out !== chan_t'(6) || data_out !== data_in[6]) begin
      errors++; $display("FAIL single_next: got chan=%0d data=%h expected chan=6 data=%h", chan_out, data_out, data_in[6]);
    end
    vld_in = '0;
  endtask

  task automatic test_backpressure();
    pkt_t a0, a1, b0;
    a0 = rand_pkt(); a1 = rand_pkt(); b0 = rand_pkt();
    do_reset();
    rdy_in     = 1'b0;
    vld_in     = 8'b0100_0100;
    data_in[2] = a0;
    data_in[6] = b0;
    #1;
    checks++;
    if (rdy_out !== 8'b0000_0100) begin errors++; $display("FAIL bp_first: got %b expected 00000100", rdy_out); end
    tick();
    data_in[2] = a1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (rdy_out !== '0) begin errors++; $display("FAIL bp_rdy[%0d]: got %b expected 0", k, rdy_out); end
      checks++;
      if (vld_out !== 1'b1 || chan_out !== chan_t'(2) || data_out !== a0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b chan=%0d data=%h expected vld=1 chan=2 data=%h",
                 k, vld_out, chan_out, data_out, a0);
      end
      tick();
    end
    rdy_in = 1'b1;
    #1;
    checks++;
    if (rdy_out !== 8'b0100_0000) begin errors++; $display("FAIL bp_grant6: got %b expected 01000000", rdy_out); end
    tick();
    vld_in = 8'b0000_0100;
    #1;
    checks++;
    if (chan_out !== chan_t'(6) || data_out !== b0) begin
      errors++; $display("FAIL bp_out6: got chan=%0d data=%h expected chan=6 data=%h", chan_out, data_out, b0);
    end
    checks++;
    if (rdy_out !== 8'b0000_0100) begin errors++; $display("FAIL bp_grant2: got %b expected 00000100", rdy_out); end
    tick();
    vld_in = '0;
    #1;
    checks++;
    if (chan_out !== chan_t'(2) || data_out !== a1) begin
      errors++; $display("FAIL bp_out2: got chan=%0d data=%h expected chan=2 data=%h", chan_out, data_out, a1);
    end
    tick();
    checks++;
    if (vld_out !== 1'b0) begin errors++; $display("FAIL bp_empty: got vld=%b expected 0", vld_out); end
    checks++;
    if (cnt_out !== 32'd3) begin errors++; $display("FAIL bp_cnt: got %0d expected 3", cnt_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy_in = 1'b1;
    vld_in = 8'b0000_0001;
    data_in[0] = rand_pkt();
    tick();
    vld_in = 8'b0000_0100;
    data_in[2] = rand_pkt();
    tick();
    rdy_in = 1'b0;
    vld_in = '0;
    #1;
    checks++;
    if (vld_out !== 1'b1 || chan_out !== chan_t'(2) || cnt_out !== 32'd1) begin
      errors++; $display("FAIL mid_setup: got vld=%b chan=%0d cnt=%0d expected vld=1 chan=2 cnt=1", vld_out, chan_out, cnt_out);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (vld_out !== 1'b0 || cnt_out !== 32'd0 || data_out !== '0) begin
      errors++; $display("FAIL mid_reset: got vld=%b cnt=%0d data=%h expected vld=0 cnt=0 data=0", vld_out, cnt_out, data_out);
    end
    reset  = 1'b0;
    rdy_in = 1'b1;
    vld_in = 8'b0001_0010;
    data_in[1] = rand_pkt();
    data_in[4] = rand_pkt();
    #1;
    checks++;
    if (rdy_out !== 8'b0000_0010) begin errors++; $display("FAIL mid_first_grant: got %b expected 00000010", rdy_out); end
    tick();
    checks++;
    if (chan_out !== chan_t'(1) || data_out !== data_in[1]) begin
      errors++; $display("FAIL mid_out: got chan=%0d data=%h expected chan=1 data=%h", chan_out, data_out, data_in[1]);
    end
    vld_in = '0;
  endtask

  task automatic test_random();
    int           g;
    int           m_ptr;
    bit           m_vld;
    int           delivered;
    logic [N-1:0] exp_rdy;
    pkt_t         exp_pkt;
    do_reset();
    m_ptr = 0; m_vld = 1'b0; delivered = 0;
    for (int i = 0; i < N; i++) begin
      sb_q[i].delete();
      seq_n[i]    = 0;
      wait_cnt[i] = 0;
      head[i]     = mk_pkt(i, 0);
    end
    for (int c = 0; c < 10003; c++) begin
      for (int i = 0; i < N; i++) begin
        vld_in[i]  = (c < 10000) && ($urandom_range(0, 99) < 60);
        data_in[i] = head[i];
      end
      rdy_in = (c >= 10000) || ($urandom_range(0, 99) < 70);
      #1;
      // Spec-level grant: first valid channel scanning circularly from the pointer.
      g = -1;
      if (!m_vld || rdy_in) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && vld_in[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      checks++;
      if (rdy_out !== exp_rdy) begin errors++; $display("FAIL rand_rdy@%0d: got %b expected %b", c, rdy_out, exp_rdy); end
      checks++;
      if (vld_out !== m_vld) begin errors++; $display("FAIL rand_vld@%0d: got %b expected %b", c, vld_out, m_vld); end
      checks++;
      if (cnt_out !== 32'(delivered)) begin errors++; $display("FAIL rand_cnt@%0d: got %0d expected %0d", c, cnt_out, delivered); end
      if (m_vld && rdy_in) begin
        checks++;
        if (sb_q[chan_out].size() == 0) begin
          errors++; $display("FAIL rand_spurious@%0d: got chan=%0d data=%h expected no pending packet", c, chan_out, data_out);
        end else begin
          exp_pkt = sb_q[chan_out].pop_front();
          if (data_out !== exp_pkt) begin
            errors++; $display("FAIL rand_order@%0d: got chan=%0d data=%h expected %h", c, chan_out, data_out, exp_pkt);
          end
        end
        delivered++;
        m_vld = 1'b0;
      end
      if (g >= 0) begin
        sb_q[g].push_back(head[g]);
        seq_n[g]++;
        head[g] = mk_pkt(g, seq_n[g]);
        m_vld   = 1'b1;
        m_ptr   = (g + 1) % N;
        for (int i = 0; i < N; i++) begin
          if (i == g || !vld_in[i]) wait_cnt[i] = 0;
          else begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] >= N) begin
              errors++; $display("FAIL rand_fair@%0d: chan %0d got %0d grants passed expected < %0d", c, i, wait_cnt[i], N);
            end
          end
        end
      end else begin
        for (int i = 0; i < N; i++) if (!vld_in[i]) wait_cnt[i] = 0;
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sb_q[i].size() != 0) begin errors++; $display("FAIL rand_lost chan %0d: got %0d undelivered expected 0", i, sb_q[i].size()); end
    end
    checks++;
    if (cnt_out !== 32'(delivered)) begin errors++; $display("FAIL rand_final_cnt: got %0d expected %0d", cnt_out, delivered); end
  endtask

  initial begin
    test_reset();
    test_all_channels();
    test_single_channel();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
